// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master
//  Purpose  : Turns single commands into AXI4-Lite read or write
//             transactions. The master waits for each channel handshake,
//             checks every wait against a timeout, and returns one response
//             per command.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          : clock (rising edge); asynchronous active-low reset
//    cmd_*               : command request (valid/ready, write, addr, wdata,
//                          wstrb)
//    rsp_*               : transaction result (valid/ready, rdata, resp)
//    aw*, w*, b*         : AXI4-Lite write address, write data and write
//                          response channels
//    ar*, r*             : AXI4-Lite read address and read data channels
//  Parameter
//    TIMEOUT_CYCLES      : number of cycles allowed for each channel wait.
//                          A value of 0 disables the timeout.
// ============================================================================
module axi_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // response interface
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  // write address channel
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // read address channel
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_RESP      = 3'd2;
  localparam logic [2:0] ST_RD_ADDR      = 3'd3;
  localparam logic [2:0] ST_RD_DATA      = 3'd4;
  localparam logic [2:0] ST_RESP         = 3'd5;

  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [31:0] r_wait_cnt;
  logic [31:0] w_wait_cnt_nxt;

  logic        w_cmd_ready_nxt;
  logic        w_rsp_valid_nxt;
  logic [31:0] w_rsp_rdata_nxt;
  logic [1:0]  w_rsp_resp_nxt;
  logic [31:0] w_awaddr_nxt;
  logic        w_awvalid_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_wstrb_nxt;
  logic        w_wvalid_nxt;
  logic        w_bready_nxt;
  logic [31:0] w_araddr_nxt;
  logic        w_arvalid_nxt;
  logic        w_rready_nxt;

  logic w_timeout;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_in_wait;

  assign awprot = 3'b000;
  assign arprot = 3'b000;

  // The counter is cleared on entry, so the value TIMEOUT_CYCLES-1 marks the
  // last allowed cycle. The outputs drop at the edge that ends that cycle,
  // which keeps each valid/ready high for exactly TIMEOUT_CYCLES cycles.
  assign w_timeout = (TIMEOUT_CYCLES != 32'd0) &&
                     (r_wait_cnt == (TIMEOUT_CYCLES - 32'd1));

  // A channel is finished when its valid has already dropped or when it
  // completes its handshake in this cycle.
  assign w_aw_ok = !awvalid || awready;
  assign w_w_ok  = !wvalid  || wready;

  assign w_in_wait = (r_state == ST_WR_ADDR_DATA) || (r_state == ST_WR_RESP) ||
                     (r_state == ST_RD_ADDR)      || (r_state == ST_RD_DATA);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_resp   <= '0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      cmd_ready  <= w_cmd_ready_nxt;
      rsp_valid  <= w_rsp_valid_nxt;
      rsp_rdata  <= w_rsp_rdata_nxt;
      rsp_resp   <= w_rsp_resp_nxt;
      awaddr     <= w_awaddr_nxt;
      awvalid    <= w_awvalid_nxt;
      wdata      <= w_wdata_nxt;
      wstrb      <= w_wstrb_nxt;
      wvalid     <= w_wvalid_nxt;
      bready     <= w_bready_nxt;
      araddr     <= w_araddr_nxt;
      arvalid    <= w_arvalid_nxt;
      rready     <= w_rready_nxt;
    end
  end

  // Next-state logic. A handshake is always tested before the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_state_nxt = cmd_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR_DATA: begin
        if (w_aw_ok && w_w_ok) begin
          w_state_nxt = ST_WR_RESP;
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (arready) begin
          w_state_nxt = ST_RD_DATA;
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RD_DATA: begin
        if (rvalid || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. It computes the next value of every registered output.
  always_comb begin
    w_rsp_rdata_nxt = rsp_rdata;
    w_rsp_resp_nxt  = rsp_resp;
    w_awaddr_nxt    = awaddr;
    w_wdata_nxt     = wdata;
    w_wstrb_nxt     = wstrb;
    w_araddr_nxt    = araddr;

    // These outputs depend only on the state being entered. A timeout goes
    // straight to RESP, so it clears all of them together.
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_bready_nxt    = (w_state_nxt == ST_WR_RESP);
    w_arvalid_nxt   = (w_state_nxt == ST_RD_ADDR);
    w_rready_nxt    = (w_state_nxt == ST_RD_DATA);

    // AW and W retire on their own handshakes, so each one holds its valid
    // only while it is still pending.
    w_awvalid_nxt = (w_state_nxt == ST_WR_ADDR_DATA) && awvalid && !awready;
    w_wvalid_nxt  = (w_state_nxt == ST_WR_ADDR_DATA) && wvalid  && !wready;

    if (w_state_nxt != r_state) begin
      w_wait_cnt_nxt = '0;
    end else if (w_in_wait) begin
      w_wait_cnt_nxt = r_wait_cnt + 32'd1;
    end else begin
      w_wait_cnt_nxt = r_wait_cnt;
    end

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            w_awaddr_nxt  = cmd_addr;
            w_wdata_nxt   = cmd_wdata;
            w_wstrb_nxt   = cmd_wstrb;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_araddr_nxt  = cmd_addr;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        if (w_state_nxt == ST_RESP) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = RESP_TIMEOUT;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = bresp;
        end else if (w_timeout) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = RESP_TIMEOUT;
        end
      end
      ST_RD_ADDR: begin
        if (!arready && w_timeout) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = RESP_TIMEOUT;
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          w_rsp_rdata_nxt = rdata;
          w_rsp_resp_nxt  = rresp;
        end else if (w_timeout) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = RESP_TIMEOUT;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master
//  Purpose  : Self-checking bench for axi_lite_master. The slave model has
//             a programmable wait on each channel. Expected responses are
//             queued when a command is issued and compared when the
//             response handshake occurs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  axi_lite_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t exp_q[$];
  exp_t sb_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave settings: number of wait cycles before ready/valid on each channel
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = '0, rresp_val = '0;
  logic [31:0] rdata_val = '0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

  // monitor results
  int aw_hi, w_hi, ar_hi, rr_hi, bready_first, rsp_rise, aw_hs_cyc, w_hs_cyc, acc_cyc;
  logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0;
  logic [3:0]  got_wstrb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and channel monitor. Both update on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (awvalid) begin awready = (aw_wait == aw_delay); aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait == w_delay); w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (arvalid) begin arready = (ar_wait == ar_delay); ar_wait++; end
      else begin arready = 1'b0; ar_wait = 0; end
      if (bready) begin bvalid = (b_wait == b_delay); bresp = bresp_val; b_wait++; end
      else begin bvalid = 1'b0; b_wait = 0; end
      if (rready) begin
        rvalid = (r_wait == r_delay); rdata = rdata_val; rresp = rresp_val; r_wait++;
      end else begin rvalid = 1'b0; r_wait = 0; end
    end
    if (awvalid && awready) begin aw_hs_cyc = cyc; got_awaddr = awaddr; end
    if (wvalid && wready) begin w_hs_cyc = cyc; got_wdata = wdata; got_wstrb = wstrb; end
    if (arvalid && arready) got_araddr = araddr;
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (arvalid) ar_hi++;
    if (rready) rr_hi++;
    if (bready && bready_first < 0) bready_first = cyc;
    if (rsp_valid && rsp_rise < 0) rsp_rise = cyc;
  end

  // Response scoreboard
  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h resp=%b, required no response", rsp_rdata, rsp_resp);
      end else begin
        sb_e = exp_q.pop_front();
        if ({rsp_rdata, rsp_resp} !== sb_e) begin
          errors++;
          $display("FAIL rsp_scoreboard: got rdata=%h resp=%b, required rdata=%h resp=%b",
                   rsp_rdata, rsp_resp, sb_e.rdata, sb_e.resp);
        end
      end
    end
  end

  task automatic reset_mon();
    aw_hi = 0; w_hi = 0; ar_hi = 0; rr_hi = 0;
    bready_first = -1; rsp_rise = -1; aw_hs_cyc = -1; w_hs_cyc = -1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st);
    int budget = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
    if (budget >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", budget);
    end
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin @(negedge clk); budget++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done: %0d responses outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    checks++; if ({rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes: got %b, required 000000", {rsp_valid, awvalid, wvalid, bready, arvalid, rready}); end
    checks++; if ({awaddr, wdata, araddr, rsp_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_addr_data: got %h %h %h %h, required all 0", awaddr, wdata, araddr, rsp_rdata); end
    checks++; if ({wstrb, rsp_resp, awprot, arprot} !== 12'b0) begin
      errors++; $display("FAIL reset_strb_resp_prot: got %b, required 0", {wstrb, rsp_resp, awprot, arprot}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    reset_mon();
    bresp_val = 2'b00;
    exp_q.push_back({32'h0, 2'b00});
    issue_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_done("wr_zero_wait");
    checks++; if (aw_hs_cyc !== acc_cyc + 1 || w_hs_cyc !== acc_cyc + 1) begin
      errors++; $display("FAIL wr0_aw_w_same_cycle: got aw=%0d w=%0d, required both %0d", aw_hs_cyc, w_hs_cyc, acc_cyc + 1); end
    checks++; if (got_awaddr !== 32'h0000_0010) begin errors++; $display("FAIL wr0_awaddr: got %h, required 00000010", got_awaddr); end
    checks++; if (got_wdata !== 32'hDEAD_BEEF || got_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr0_wdata: got %h/%h, required deadbeef/f", got_wdata, got_wstrb); end
    checks++; if (rsp_rise !== acc_cyc + 3) begin
      errors++; $display("FAIL wr0_latency: got %0d cycles, required 3", rsp_rise - acc_cyc); end
  endtask

  task automatic test_write_aw_delay();
    reset_mon();
    aw_delay = 3; bresp_val = 2'b10;
    exp_q.push_back({32'h0, 2'b10});
    issue_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b0101);
    wait_done("wr_aw_delay");
    aw_delay = 0;
    checks++; if (w_hi !== 1) begin errors++; $display("FAIL wr_dly_wvalid_len: got %0d, required 1", w_hi); end
    checks++; if (aw_hi !== 4) begin errors++; $display("FAIL wr_dly_awvalid_len: got %0d, required 4", aw_hi); end
    checks++; if (bready_first !== acc_cyc + 5) begin
      errors++; $display("FAIL wr_dly_bready: got cycle %0d, required %0d", bready_first - acc_cyc, 5); end
    checks++; if (got_wstrb !== 4'b0101 || got_awaddr !== 32'h20) begin
      errors++; $display("FAIL wr_dly_payload: got %h/%h, required 00000020/5", got_awaddr, got_wstrb); end
  endtask

  task automatic test_read();
    reset_mon();
    rdata_val = 32'h1234_5678; rresp_val = 2'b10;
    exp_q.push_back({32'h1234_5678, 2'b10});
    issue_cmd(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
    wait_done("rd");
    checks++; if (got_araddr !== 32'h0000_0004) begin errors++; $display("FAIL rd_araddr: got %h, required 00000004", got_araddr); end
    checks++; if (rsp_rise !== acc_cyc + 3) begin errors++; $display("FAIL rd_latency: got %0d cycles, required 3", rsp_rise - acc_cyc); end
    checks++; if (rr_hi !== 1) begin errors++; $display("FAIL rd_rready_len: got %0d, required 1", rr_hi); end
  endtask

  task automatic test_timeout();
    reset_mon();
    ar_delay = 1000; rdata_val = 32'hCAFE_F00D; rresp_val = 2'b00;
    exp_q.push_back({32'h0, 2'b11});
    issue_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    wait_done("timeout");
    ar_delay = 0;
    checks++; if (ar_hi !== 8) begin errors++; $display("FAIL to_arvalid_len: got %0d, required 8", ar_hi); end
    checks++; if (rr_hi !== 0) begin errors++; $display("FAIL to_rready: got %0d cycles, required 0", rr_hi); end
    checks++; if (rsp_rise !== acc_cyc + 9) begin errors++; $display("FAIL to_rsp_time: got %0d, required 9", rsp_rise - acc_cyc); end
  endtask

  task automatic test_rsp_backpressure();
    int budget = 0;
    reset_mon();
    rsp_ready = 1'b0; rdata_val = 32'h0BAD_F00D; rresp_val = 2'b01;
    exp_q.push_back({32'h0BAD_F00D, 2'b01});
    issue_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    while (!rsp_valid && budget < 50) begin @(negedge clk); budget++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_resp !== 2'b01) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h r=%b, required v=1 d=0badf00d r=01", i, rsp_valid, rsp_rdata, rsp_resp); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d]: got %b, required 0", i, cmd_ready); end
    end
    rsp_ready = 1'b1;
    wait_done("backpressure");
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    reset_mon();
    b_delay = 1000;
    exp_q.push_back({32'h0, 2'b00});
    issue_cmd(1'b1, 32'h0000_0030, 32'h1111_2222, 4'h3);
    while (!bready && budget < 50) begin @(negedge clk); budget++; end
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rstmid_reach_wr_resp: got bready %b, required 1", bready); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if ({bready, awvalid, wvalid, rsp_valid} !== 4'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_handshakes: got b=%b aw=%b w=%b rv=%b cr=%b, required 0 0 0 0 1", bready, awvalid, wvalid, rsp_valid, cmd_ready); end
    checks++; if ({awaddr, wdata, wstrb} !== 68'b0) begin
      errors++; $display("FAIL rstmid_payload: got %h %h %h, required 0", awaddr, wdata, wstrb); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; b_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rstmid_no_rsp[%0d]: got rsp_valid=%b cmd_ready=%b, required 0 1", i, rsp_valid, cmd_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic        wr;
    logic [31:0] addr, wd;
    logic [3:0]  st;
    for (int i = 0; i < 8; i++) begin
      reset_mon();
      wr = 1'($urandom_range(0, 1)); addr = $urandom; wd = $urandom; st = 4'($urandom_range(0, 15));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      bresp_val = 2'($urandom_range(0, 3)); rresp_val = 2'($urandom_range(0, 3)); rdata_val = $urandom;
      if (wr) exp_q.push_back({32'h0, bresp_val});
      else    exp_q.push_back({rdata_val, rresp_val});
      issue_cmd(wr, addr, wd, st);
      wait_done("b2b");
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_next[%0d]: got %b, required 1", i, cmd_ready); end
      checks++;
      if (wr && (got_awaddr !== addr || got_wdata !== wd || got_wstrb !== st)) begin
        errors++; $display("FAIL b2b_wr_payload[%0d]: got %h/%h/%h, required %h/%h/%h", i, got_awaddr, got_wdata, got_wstrb, addr, wd, st);
      end else if (!wr && got_araddr !== addr) begin
        errors++; $display("FAIL b2b_araddr[%0d]: got %h, required %h", i, got_araddr, addr);
      end
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
  endtask

  initial begin
    reset_mon();
    test_reset();
    test_write_zero_wait();
    test_write_aw_delay();
    test_read();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024; cycles allowed per AXI channel wait, 0 = timeout disabled.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  target byte address.
REQ-008 cmd_wdata  input  32  write data (ignored for reads).
REQ-009 cmd_wstrb  input  4  write byte strobes (ignored for reads).
REQ-010 rsp_valid  output  1  transaction result available.
REQ-011 rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_resp  output  2  BRESP/RRESP as received; 2'b11 on timeout.
REQ-014 AWADDR, AWVALID  output  32, 1  write address channel; AWREADY input 1.
REQ-015 WDATA, WSTRB, WVALID  output  32, 4, 1  write data channel; WREADY input 1.
REQ-016 BREADY  output  1; BVALID input 1; BRESP input 2  write response channel.
REQ-017 ARADDR, ARVALID  output  32, 1  read address channel; ARREADY input 1.
REQ-018 RREADY  output  1; RVALID input 1; RDATA input 32; RRESP input 2  read data channel.
REQ-019 AWPROT, ARPROT  output  3  constant 3'b000.

Function
REQ-020 States SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP; all outputs registered.
REQ-021 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, addr/data/strb latched, next state WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-022 WR_ADDR_DATA: AWVALID and WVALID SHALL assert in the first cycle of the state, simultaneously; each deasserts the cycle after its own handshake, independently; AWADDR/WDATA/WSTRB stable while valid.
REQ-023 When both AW and W handshakes are complete (same or different cycles), SHALL go to WR_RESP with BREADY=1.
REQ-024 WR_RESP: on BVALID, SHALL capture BRESP into rsp_resp, rsp_rdata=0, deassert BREADY, enter RESP.
REQ-025 RD_ADDR: ARVALID=1 with ARADDR stable until ARREADY; then ARVALID=0, RREADY=1, enter RD_DATA.
REQ-026 RD_DATA: on RVALID, SHALL capture RDATA/RRESP, deassert RREADY, enter RESP.
REQ-027 RESP: rsp_valid=1 held with rsp_rdata/rsp_resp stable until rsp_ready; then rsp_valid=0, return to IDLE; next command acceptable the following cycle.
REQ-028 Minimum latency, zero-wait slave: write cmd accept -> rsp_valid in 3 cycles; read same.
REQ-029 Wait counter SHALL clear on every state entry and increment each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-030 When counter reaches TIMEOUT_CYCLES (nonzero): all AXI valid/ready outputs deassert next cycle, rsp_resp=2'b11, rsp_rdata=0, enter RESP; recovery-only, slave state not guaranteed.
REQ-031 Handshake and timeout in same cycle: handshake SHALL take priority.
REQ-032 Error responses (SLVERR/DECERR) SHALL be passed through unchanged; no retry.
REQ-033 Read data SHALL never be captured outside RD_DATA; BVALID/RVALID outside wait states ignored.

Reset
REQ-034 During reset: state IDLE; cmd_ready=1; rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY=0; all address/data/resp outputs=0; counter=0.
REQ-035 Reset mid-transaction SHALL abort immediately to reset values; no response issued for the aborted command.

Verification
REQ-036 Write 0x0000_0010 data 0xDEAD_BEEF strb 4'hF, zero-wait slave -> AW and W same cycle, rsp_resp=00 three cycles after accept.
REQ-037 Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, BREADY only after both.
REQ-038 Read 0x0000_0004, slave RDATA=0x1234_5678 RRESP=10 -> rsp_rdata=0x1234_5678, rsp_resp=10.
REQ-039 TIMEOUT_CYCLES=8, ARREADY never asserted -> ARVALID drops after 8 cycles, rsp_resp=11, rsp_rdata=0.
REQ-040 rsp_ready held low 5 cycles -> rsp_valid/data stable, cmd_ready=0; rst_n low during WR_RESP -> all outputs at reset values, no rsp_valid.
